uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, meaning system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries; power of two, 4..256.
REQ-004 SHALL have port clk_clk  input  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port reset_reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port uart_rxd  input  1  serial line from the Nios UART txd; idle high; asynchronous to clk_clk.
REQ-007 SHALL have port rx_data  output  8  byte at the FIFO head.
REQ-008 SHALL have port rx_valid  output  1  FIFO is non-empty.
REQ-009 SHALL have port rx_ready  input  1  consumer accepts rx_data.
REQ-010 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse when a frame's stop bit samples low.
REQ-012 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Function
REQ-013 SHALL pass uart_rxd through a 2-flop synchronizer, reset value 1, before any use.
REQ-014 SHALL generate a 16x oversample tick every DIV = CLK_HZ/(BAUD*16) clocks (integer division; 27 at defaults); the divider restarts at 0 on leaving IDLE.
REQ-015 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH (plus PARITY when configured).
REQ-016 IDLE -> START on a synchronized high-to-low transition.
REQ-017 START: at tick 8, line low -> DATA; line high -> IDLE (glitch rejected, no error).
REQ-018 DATA: sample every 16 ticks after the start-bit midpoint, shift LSB first; after 8 bits -> STOP (or PARITY).
REQ-019 STOP: sample high -> push byte and go to IDLE; sample low -> pulse frame_err, discard byte, go to WAIT_HIGH.
REQ-020 WAIT_HIGH -> IDLE once the synchronized line is high (break condition yields exactly one frame_err).
REQ-021 Push latency: byte SHALL appear on rx_data with rx_valid high 2 clocks after the stop-bit sample.
REQ-022 Pop SHALL occur on any clock where rx_valid && rx_ready; rx_data/rx_valid SHALL be registered FIFO-head values and stay stable while rx_valid && !rx_ready.
REQ-023 Push when full without simultaneous pop SHALL drop the new byte, keep the FIFO unchanged, and pulse overrun.
REQ-024 Simultaneous push and pop SHALL both complete (including when full, with no overrun); fifo_level unchanged.
REQ-025 Read/write pointers SHALL wrap modulo FIFO_DEPTH; fifo_level SHALL never exceed FIFO_DEPTH.

Reset
REQ-026 Reset assertion SHALL force IDLE, empty FIFO, rx_valid=0, rx_data=0, fifo_level=0, frame_err=0, overrun=0, synchronizer=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame; after release the receiver SHALL wait for a fresh falling edge.

Configuration
REQ-028 With macro UART_RX_PARITY_EN defined, a PARITY state SHALL follow DATA and check even parity; mismatch SHALL discard the byte and pulse frame_err.
REQ-029 Without UART_RX_PARITY_EN, frames SHALL be 8N1 and no parity logic SHALL be synthesized.

Structure
REQ-030 Package uart_pkg SHALL hold the receiver state enum, OVERSAMPLE=16, and SAMPLE_MID=8.
REQ-031 FIFO storage and pointers SHALL be a sub-module uart_sync_fifo (parameterized width/depth, registered output).

Verification (CLK_HZ=50000000, BAUD=115200, bit = 432 clocks)
REQ-032 Send 0xA5 8N1 -> rx_data=0xA5 and rx_valid=1; fifo_level=1; no error pulses.
REQ-033 Send 17 bytes 0x00..0x10 with rx_ready=0, DEPTH=16 -> one overrun pulse on the 17th byte; drain yields 0x00..0x0F in order.
REQ-034 Send 0x3C with stop bit forced low, then hold the line low 5 bit times -> exactly one frame_err; FIFO empty; next good byte 0x55 is received.
REQ-035 Apply a 200-clock low glitch on the idle line -> no byte, no error, state returns to IDLE.
REQ-036 Assert reset at data bit 4 of 0xFF, release, send 0x12 -> only 0x12 is received.
REQ-037 Fill to 16, then hold rx_ready=1 while a 17th byte arrives -> no overrun; level stays 16 on that push cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: receiver state encoding, oversampling constants and baud divider helper
package uart_pkg;
  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_MID = 8;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz / (baud * OVERSAMPLE) < 1) ? 1 : clk_hz / (baud * OVERSAMPLE);
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: power-of-two FIFO with registered head data/valid, drop pulse on full push
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_wr,
  input  logic [WIDTH-1:0]         i_din,
  input  logic                     i_rd,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_valid,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_drop
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             r_drop;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_bypass;
  logic [AW-1:0]    w_rd_ptr_n;
  logic [AW:0]      w_count_n;
  assign w_full     = r_count == (AW+1)'(DEPTH);
  assign w_pop      = i_rd & r_valid;
  assign w_push     = i_wr & (!w_full | w_pop);
  assign w_rd_ptr_n = r_rd_ptr + AW'(w_pop);
  assign w_count_n  = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  // A push into an otherwise-empty FIFO must reach the head register directly
  assign w_bypass   = w_push & (r_count == (AW+1)'(w_pop));
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr_ptr] <= i_din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_valid  <= 1'b0;
      r_drop   <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(w_push);
      r_rd_ptr <= w_rd_ptr_n;
      r_count  <= w_count_n;
      r_valid  <= w_count_n != '0;
      r_dout   <= (w_count_n == '0) ? r_dout : w_bypass ? i_din : r_mem[w_rd_ptr_n];
      r_drop   <= i_wr & w_full & !w_pop;
    end
  assign o_dout  = r_dout;
  assign o_valid = r_valid;
  assign o_level = r_count;
  assign o_drop  = r_drop;
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampled UART receiver into a FIFO; even parity when UART_RX_PARITY_EN is defined
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk_clk,
  input  logic                            reset_reset_n,
  input  logic                            uart_rxd,
  output logic [7:0]                      rx_data,
  output logic                            rx_valid,
  input  logic                            rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            frame_err,
  output logic                            overrun
);
  localparam int DIV = baud_div(CLK_HZ, BAUD);
  localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
  rx_state_e r_state, w_state_n;
  logic          r_rxd_s1, r_rxd_s2, r_rxd_q;
  logic [1:0]    r_flush;
  logic [DW-1:0] r_div;
  logic [3:0]    r_tick, w_tick_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [7:0]    r_shift, w_shift_n;
  logic          r_push_pend, r_push;
  logic [7:0]    r_push_data;
  logic          r_frame_err;
  logic          w_rxd, w_fall, w_tick, w_mid, w_sample;
  logic          w_push, w_ferr, w_par_bad;
`ifdef UART_RX_PARITY_EN
  localparam rx_state_e AFTER_DATA = ST_PARITY;
  logic r_par_err, w_par_err_n;
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) r_par_err <= 1'b0;
    else r_par_err <= w_par_err_n;
  assign w_par_bad = r_par_err;
`else
  localparam rx_state_e AFTER_DATA = ST_STOP;
  assign w_par_bad = 1'b0;
`endif
  assign w_rxd    = r_rxd_s2;
  // r_rxd_q only reports high once the synchronizer holds real line samples, so a line
  // that is already low when reset releases is not mistaken for a start edge
  assign w_fall   = r_rxd_q & !w_rxd;
  assign w_tick   = r_div == DW'(DIV - 1);
  assign w_mid    = w_tick && r_tick == 4'(SAMPLE_MID - 1);
  assign w_sample = w_tick && r_tick == 4'(OVERSAMPLE - 1);
  always_comb begin
    w_state_n = r_state;
    w_tick_n  = w_tick ? r_tick + 4'd1 : r_tick;
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_push    = 1'b0;
    w_ferr    = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_err_n = r_par_err;
`endif
    case (r_state)
      ST_IDLE: begin
        w_tick_n = '0;
        if (w_fall) w_state_n = ST_START;
      end
      ST_START:
        if (w_mid) begin
          w_tick_n  = '0;
          w_bit_n   = '0;
          w_state_n = w_rxd ? ST_IDLE : ST_DATA;
        end
      ST_DATA:
        if (w_sample) begin
          w_tick_n  = '0;
          w_shift_n = {w_rxd, r_shift[7:1]};
          w_bit_n   = r_bit + 3'd1;
          w_state_n = (r_bit == 3'd7) ? AFTER_DATA : ST_DATA;
        end
`ifdef UART_RX_PARITY_EN
      ST_PARITY:
        if (w_sample) begin
          w_tick_n    = '0;
          w_par_err_n = ^{r_shift, w_rxd};
          w_state_n   = ST_STOP;
        end
`endif
      ST_STOP:
        if (w_sample) begin
          w_tick_n  = '0;
          w_state_n = w_rxd ? ST_IDLE : ST_WAIT_HIGH;
          w_push    = w_rxd & !w_par_bad;
          w_ferr    = !w_rxd | w_par_bad;
        end
      ST_WAIT_HIGH:
        if (w_rxd) w_state_n = ST_IDLE;
      default: w_state_n = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      r_rxd_s1    <= 1'b1;
      r_rxd_s2    <= 1'b1;
      r_rxd_q     <= 1'b0;
      r_flush     <= '0;
      r_state     <= ST_IDLE;
      r_div       <= '0;
      r_tick      <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_push_pend <= 1'b0;
      r_push      <= 1'b0;
      r_push_data <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_rxd_s1    <= uart_rxd;
      r_rxd_s2    <= r_rxd_s1;
      r_rxd_q     <= r_rxd_s2 & r_flush[1];
      r_flush     <= {r_flush[0], 1'b1};
      r_state     <= w_state_n;
      r_div       <= (r_state == ST_IDLE || w_tick) ? '0 : r_div + DW'(1);
      r_tick      <= w_tick_n;
      r_bit       <= w_bit_n;
      r_shift     <= w_shift_n;
      r_push_pend <= w_push;
      r_push      <= r_push_pend;
      r_push_data <= w_push ? r_shift : r_push_data;
      r_frame_err <= w_ferr;
    end
  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk_clk),
    .rst_n   (reset_reset_n),
    .i_wr    (r_push),
    .i_din   (r_push_data),
    .i_rd    (rx_ready),
    .o_dout  (rx_data),
    .o_valid (rx_valid),
    .o_level (fifo_level),
    .o_drop  (overrun)
  );
  assign frame_err = r_frame_err;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: scoreboard bench; dut0 at 115200 baud, dut1 at 921600 baud for the long fill run
module tb_uart_rx_fifo;
  localparam int DIV0 = 50000000 / (115200 * 16);
  localparam int DIV1 = 50000000 / (921600 * 16);
  localparam int BT0  = 16 * DIV0;
  localparam int BT1  = 16 * DIV1;
  // start edge to visible byte: 2 sync + 1 edge detect, 8 ticks to start mid, 9 bit periods, 2 push
  localparam int PE0  = 5 + (8 + 9 * 16) * DIV0;
  localparam int PE1  = 5 + (8 + 9 * 16) * DIV1;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] rxd = 2'b11;
  logic [1:0] rdy = 2'b00;
  logic [1:0] valid, ferr, ovr;
  logic [7:0] data0, data1;
  logic [4:0] lvl0, lvl1;
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  int n_chk = 0;
  int n_fail = 0;
  int ferr_cnt [2] = '{0, 0};
  int ovr_cnt [2] = '{0, 0};
  logic       vp, va;
  logic [4:0] la;
  logic [7:0] da;
  always #10 clk = ~clk;
  uart_rx_fifo #(.CLK_HZ(50000000), .BAUD(115200), .FIFO_DEPTH(16)) u_dut0 (
    .clk_clk(clk), .reset_reset_n(rst_n), .uart_rxd(rxd[0]), .rx_data(data0), .rx_valid(valid[0]),
    .rx_ready(rdy[0]), .fifo_level(lvl0), .frame_err(ferr[0]), .overrun(ovr[0]));
  uart_rx_fifo #(.CLK_HZ(50000000), .BAUD(921600), .FIFO_DEPTH(16)) u_dut1 (
    .clk_clk(clk), .reset_reset_n(rst_n), .uart_rxd(rxd[1]), .rx_data(data1), .rx_valid(valid[1]),
    .rx_ready(rdy[1]), .fifo_level(lvl1), .frame_err(ferr[1]), .overrun(ovr[1]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (valid[0] && rdy[0]) begin
      chk("dut0_pop_expected", 32'(q0.size() > 0), 1);
      if (q0.size() > 0) chk("dut0_data", 32'(data0), 32'(q0.pop_front()));
    end
    if (valid[1] && rdy[1]) begin
      chk("dut1_pop_expected", 32'(q1.size() > 0), 1);
      if (q1.size() > 0) chk("dut1_data", 32'(data1), 32'(q1.pop_front()));
    end
    if (ferr[0]) ferr_cnt[0]++;
    if (ferr[1]) ferr_cnt[1]++;
    if (ovr[0]) ovr_cnt[0]++;
    if (ovr[1]) ovr_cnt[1]++;
  end
  task automatic hold(input int s, input logic v, input int n);
    rxd[s] = v;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic frame(input int s, input logic [7:0] b, input logic sv, input logic pop,
                       output logic v_pre, output logic v_at, output logic [4:0] l_at, output logic [7:0] d_at);
    int bt, pe;
    bt = s ? BT1 : BT0;
    pe = s ? PE1 : PE0;
    hold(s, 1'b0, bt);
    for (int i = 0; i < 8; i++) hold(s, b[i], bt);
    hold(s, sv, pe - 1 - 9 * bt);
    v_pre = valid[s];
    if (pop) rdy[s] = 1'b1;
    @(posedge clk);
    #1;
    if (pop) rdy[s] = 1'b0;
    v_at = valid[s];
    l_at = s ? lvl1 : lvl0;
    d_at = s ? data1 : data0;
    hold(s, sv, bt - (pe - 9 * bt));
  endtask
  task automatic drain(input int s);
    rdy[s] = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    rdy[s] = 1'b0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_data0", 32'(data0), 0);
    chk("rst_data1", 32'(data1), 0);
    chk("rst_level0", 32'(lvl0), 0);
    chk("rst_level1", 32'(lvl1), 0);
    chk("rst_ferr", 32'(ferr), 0);
    chk("rst_ovr", 32'(ovr), 0);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      q1.push_back(8'(i));
      frame(1, 8'(i), 1'b1, 1'b0, vp, va, la, da);
    end
    chk("fill_level", 32'(lvl1), 16);
    chk("fill_valid", 32'(valid[1]), 1);
    chk("fill_no_ovr", 32'(ovr_cnt[1]), 0);
    frame(1, 8'h10, 1'b1, 1'b0, vp, va, la, da);
    chk("full_ovr_pulse", 32'(ovr_cnt[1]), 1);
    chk("full_level", 32'(la), 16);
    chk("full_head", 32'(da), 8'h00);
    q1.push_back(8'h11);
    frame(1, 8'h11, 1'b1, 1'b1, vp, va, la, da);
    chk("full_pushpop_no_ovr", 32'(ovr_cnt[1]), 1);
    chk("full_pushpop_level", 32'(la), 16);
    chk("full_pushpop_head", 32'(da), 8'h01);
    drain(1);
    chk("fill_drained_sb", 32'(q1.size()), 0);
    chk("fill_drained_level", 32'(lvl1), 0);
    chk("fill_no_ferr", 32'(ferr_cnt[1]), 0);
    q0.push_back(8'hA5);
    frame(0, 8'hA5, 1'b1, 1'b0, vp, va, la, da);
    chk("a5_not_early", 32'(vp), 0);
    chk("a5_valid", 32'(va), 1);
    chk("a5_data", 32'(da), 8'hA5);
    chk("a5_level", 32'(la), 1);
    chk("a5_no_ferr", 32'(ferr_cnt[0]), 0);
    chk("a5_no_ovr", 32'(ovr_cnt[0]), 0);
    drain(0);
    chk("a5_drained", 32'(q0.size()), 0);
    hold(0, 1'b0, 200);
    hold(0, 1'b1, 2 * BT0);
    chk("glitch_no_byte", 32'(valid[0]), 0);
    chk("glitch_level", 32'(lvl0), 0);
    chk("glitch_no_ferr", 32'(ferr_cnt[0]), 0);
    frame(0, 8'h3C, 1'b0, 1'b0, vp, va, la, da);
    hold(0, 1'b0, 5 * BT0);
    hold(0, 1'b1, BT0);
    chk("break_one_ferr", 32'(ferr_cnt[0]), 1);
    chk("break_fifo_empty", 32'(lvl0), 0);
    chk("break_no_valid", 32'(valid[0]), 0);
    q0.push_back(8'h55);
    frame(0, 8'h55, 1'b1, 1'b0, vp, va, la, da);
    chk("after_break_valid", 32'(va), 1);
    chk("after_break_data", 32'(da), 8'h55);
    drain(0);
    chk("after_break_ferr", 32'(ferr_cnt[0]), 1);
    hold(0, 1'b0, BT0);
    for (int i = 0; i < 4; i++) hold(0, 1'b1, BT0);
    hold(0, 1'b1, BT0 / 2);
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midframe_rst_valid", 32'(valid[0]), 0);
    rst_n = 1'b1;
    hold(0, 1'b1, 6 * BT0);
    chk("midframe_no_byte", 32'(valid[0]), 0);
    q0.push_back(8'h12);
    frame(0, 8'h12, 1'b1, 1'b0, vp, va, la, da);
    chk("post_rst_valid", 32'(va), 1);
    chk("post_rst_data", 32'(da), 8'h12);
    chk("post_rst_level", 32'(la), 1);
    drain(0);
    chk("final_sb0", 32'(q0.size()), 0);
    chk("final_level0", 32'(lvl0), 0);
    chk("final_ovr0", 32'(ovr_cnt[0]), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
